// File: rtl/shout_clk_bank.sv
// Bank of NCH programmable clock dividers with per-channel phase, mode and RNG jitter.
// Config is double-buffered (shadow -> active) and swapped only on a wrap to avoid runt pulses.
module shout_clk_bank #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 8,
  parameter int unsigned RW          = 5,
  parameter int unsigned DIV_DEFAULT = 4,
  parameter int unsigned JMASK       = 3,
  localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [RW-1:0]    rnd,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CW-1:0]    cfg_div,
  input  logic [CW-1:0]    cfg_phase,
  input  logic [1:0]       cfg_mode,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   strobe_out,
  output logic [NCH-1:0]   cfg_pend
);

  localparam logic [1:0] ModeToggle = 2'd0;
  localparam logic [1:0] ModePulse  = 2'd1;
  localparam logic [1:0] ModeJitter = 2'd2;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_div_q, act_div_d, act_ph_q, act_ph_d;
    logic [CW-1:0] sh_div_q, sh_div_d, sh_ph_q, sh_ph_d;
    logic [1:0]    act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
    logic [RW-1:0] rlat_q, rlat_d;
    logic          clk_q, clk_d, stb_q, stb_d, pend_q, pend_d, en_q;
    logic          sel, wrap;
    logic [CW-1:0] term, jit, ld;

    // Only indices below NCH can ever match, so out-of-range writes are dropped.
    assign sel = cfg_we && (cfg_ch == CHW'(i));

    always_comb begin
      jit  = CW'(rlat_q) & CW'(JMASK);
      term = act_div_q;
      if (act_mode_q == ModeJitter) begin
        term = act_div_q ^ jit;
        if (term == '0) term = CW'(1);
      end
      ld   = (act_ph_q < act_div_q) ? act_ph_q : act_div_q;
      wrap = ch_en[i] && en_q && (cnt_q == term);
    end

    always_comb begin
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      act_ph_d   = act_ph_q;
      act_mode_d = act_mode_q;
      sh_div_d   = sh_div_q;
      sh_ph_d    = sh_ph_q;
      sh_mode_d  = sh_mode_q;
      rlat_d     = rlat_q;
      clk_d      = clk_q;
      stb_d      = stb_q;
      pend_d     = pend_q;

      if (!ch_en[i]) begin
        clk_d = 1'b0;
        stb_d = 1'b0;
        if (sel) begin
          sh_div_d   = cfg_div;
          sh_ph_d    = cfg_phase;
          sh_mode_d  = cfg_mode;
          act_div_d  = cfg_div;
          act_ph_d   = cfg_phase;
          act_mode_d = cfg_mode;
          pend_d     = 1'b0;
        end
      end else begin
        if (!en_q) begin
          cnt_d  = ld;
          rlat_d = '0;
          clk_d  = 1'b0;
          stb_d  = 1'b0;
        end else if (wrap) begin
          cnt_d  = '0;
          rlat_d = rnd;
          unique case (act_mode_q)
            ModeToggle, ModeJitter: begin
              clk_d = ~clk_q;
              stb_d = 1'b1;
            end
            ModePulse: begin
              clk_d = 1'b1;
              stb_d = 1'b1;
            end
            default: begin
              clk_d = 1'b0;
              stb_d = 1'b0;
            end
          endcase
          // The wrap consumes the shadow as it stood before any same-cycle write.
          if (pend_q) begin
            act_div_d  = sh_div_q;
            act_ph_d   = sh_ph_q;
            act_mode_d = sh_mode_q;
            pend_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          stb_d = 1'b0;
          if (act_mode_q != ModeToggle && act_mode_q != ModeJitter) clk_d = 1'b0;
        end
        if (sel) begin
          sh_div_d  = cfg_div;
          sh_ph_d   = cfg_phase;
          sh_mode_d = cfg_mode;
          pend_d    = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        cnt_q      <= '0;
        act_div_q  <= CW'(DIV_DEFAULT);
        act_ph_q   <= '0;
        act_mode_q <= ModeToggle;
        sh_div_q   <= CW'(DIV_DEFAULT);
        sh_ph_q    <= '0;
        sh_mode_q  <= ModeToggle;
        rlat_q     <= '0;
        clk_q      <= 1'b0;
        stb_q      <= 1'b0;
        pend_q     <= 1'b0;
        en_q       <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_div_q  <= act_div_d;
        act_ph_q   <= act_ph_d;
        act_mode_q <= act_mode_d;
        sh_div_q   <= sh_div_d;
        sh_ph_q    <= sh_ph_d;
        sh_mode_q  <= sh_mode_d;
        rlat_q     <= rlat_d;
        clk_q      <= clk_d;
        stb_q      <= stb_d;
        pend_q     <= pend_d;
        en_q       <= ch_en[i];
      end
    end

    assign clk_out[i]    = clk_q;
    assign strobe_out[i] = stb_q;
    assign cfg_pend[i]   = pend_q;
  end

endmodule

// File: tb/tb_shout_clk_bank.sv
// Self-checking bench for shout_clk_bank: scoreboard queues of expected strobe intervals/times.
module tb_shout_clk_bank;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [4:0] rnd;
  logic [3:0] ch_en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div, cfg_phase;
  logic [1:0] cfg_mode;
  logic [3:0] clk_out, strobe_out, cfg_pend;

  // Three-channel instance so an out-of-range channel index is representable.
  logic [4:0] rnd2;
  logic [2:0] ch_en2;
  logic       cfg_we2;
  logic [1:0] cfg_ch2;
  logic [7:0] cfg_div2, cfg_phase2;
  logic [1:0] cfg_mode2;
  logic [2:0] clk_out2, strobe_out2, cfg_pend2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];
  int exp_clk_q[$];
  int exp2_q[$];
  int exp3_q[$];

  always #5 clk_in = ~clk_in;

  shout_clk_bank dut (
    .clk_in(clk_in), .reset(reset), .rnd(rnd), .ch_en(ch_en), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .clk_out(clk_out), .strobe_out(strobe_out), .cfg_pend(cfg_pend)
  );

  shout_clk_bank #(.NCH(3)) dut2 (
    .clk_in(clk_in), .reset(reset), .rnd(rnd2), .ch_en(ch_en2), .cfg_we(cfg_we2),
    .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .cfg_phase(cfg_phase2), .cfg_mode(cfg_mode2),
    .clk_out(clk_out2), .strobe_out(strobe_out2), .cfg_pend(cfg_pend2)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic cfg(input int ch, input int div, input int ph, input int mode);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(div);
    cfg_phase = 8'(ph);
    cfg_mode  = 2'(mode);
    tick();
    cfg_we    = 1'b0;
  endtask

  // Returns the cycle of the next strobe on ch, or -1 when the budget runs out.
  task automatic wait_strobe(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (strobe_out[ch] === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    total++;
    if (clk_out !== 4'b0) begin bad++; $display("FAIL reset_clk: got %b expected 0000", clk_out); end
    total++;
    if (strobe_out !== 4'b0) begin bad++; $display("FAIL reset_strobe: got %b expected 0000", strobe_out); end
    total++;
    if (cfg_pend !== 4'b0) begin bad++; $display("FAIL reset_pend: got %b expected 0000", cfg_pend); end
    reset = 1'b1;
    tick();
    total++;
    if ({clk_out, strobe_out, cfg_pend} !== 12'b0)
      begin bad++; $display("FAIL reset_release: got %h expected 000", {clk_out, strobe_out, cfg_pend}); end
  endtask

  task automatic test_toggle();
    int s, t, prev;
    cfg(0, 4, 0, 0);
    ch_en[0] = 1'b1;
    tick();
    s = cyc;
    prev = s;
    exp_q = '{5, 5, 5, 5};
    exp_clk_q = '{1, 0, 1, 0};
    while (exp_q.size() > 0) begin
      int ei, ec;
      ei = exp_q.pop_front();
      ec = exp_clk_q.pop_front();
      wait_strobe(0, 20, t);
      total++;
      if (t - prev !== ei) begin bad++; $display("FAIL toggle_interval: got %0d expected %0d", t - prev, ei); end
      total++;
      if (int'(clk_out[0]) !== ec) begin bad++; $display("FAIL toggle_clk: got %0d expected %0d", clk_out[0], ec); end
      prev = t;
    end
  endtask

  task automatic test_pulse();
    int t, prev;
    cfg(1, 2, 0, 1);
    ch_en[1] = 1'b1;
    tick();
    prev = cyc;
    exp_q = '{3, 3, 3};
    while (exp_q.size() > 0) begin
      int ei;
      ei = exp_q.pop_front();
      wait_strobe(1, 10, t);
      total++;
      if (t - prev !== ei) begin bad++; $display("FAIL pulse_interval: got %0d expected %0d", t - prev, ei); end
      total++;
      if (clk_out[1] !== 1'b1) begin bad++; $display("FAIL pulse_clk_hi: got %b expected 1", clk_out[1]); end
      prev = t;
    end
    tick();
    total++;
    if ({strobe_out[1], clk_out[1]} !== 2'b00)
      begin bad++; $display("FAIL pulse_low: got %b expected 00", {strobe_out[1], clk_out[1]}); end
    cfg(1, 0, 0, 1);
    total++;
    if (cfg_pend[1] !== 1'b1) begin bad++; $display("FAIL pulse_pend_set: got %b expected 1", cfg_pend[1]); end
    wait_strobe(1, 10, t);
    total++;
    if (cfg_pend[1] !== 1'b0) begin bad++; $display("FAIL pulse_pend_clr: got %b expected 0", cfg_pend[1]); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({strobe_out[1], clk_out[1]} !== 2'b11)
        begin bad++; $display("FAIL pulse_d0_held: got %b expected 11", {strobe_out[1], clk_out[1]}); end
    end
    ch_en[1] = 1'b0;
    tick();
    total++;
    if ({strobe_out[1], clk_out[1]} !== 2'b00)
      begin bad++; $display("FAIL pulse_disable: got %b expected 00", {strobe_out[1], clk_out[1]}); end
  endtask

  task automatic test_reconfig();
    int t, prev;
    wait_strobe(0, 20, t);
    prev = t;
    tick();
    tick();
    cfg(0, 9, 0, 0);
    total++;
    if (cfg_pend[0] !== 1'b1) begin bad++; $display("FAIL reconf_pend_set: got %b expected 1", cfg_pend[0]); end
    exp_q = '{5, 10, 10};
    while (exp_q.size() > 0) begin
      int ei;
      ei = exp_q.pop_front();
      wait_strobe(0, 30, t);
      total++;
      if (t - prev !== ei) begin bad++; $display("FAIL reconf_interval: got %0d expected %0d", t - prev, ei); end
      total++;
      if (cfg_pend[0] !== 1'b0) begin bad++; $display("FAIL reconf_pend_clr: got %b expected 0", cfg_pend[0]); end
      prev = t;
    end
  endtask

  task automatic test_phase();
    int s;
    cfg(2, 7, 0, 0);
    cfg(3, 7, 4, 0);
    ch_en[3:2] = 2'b11;
    tick();
    s = cyc;
    exp3_q = '{s + 4, s + 12, s + 20};
    exp2_q = '{s + 8, s + 16, s + 24};
    for (int k = 0; k < 26; k++) begin
      tick();
      if (strobe_out[2] === 1'b1) begin
        int e;
        e = (exp2_q.size() > 0) ? exp2_q.pop_front() : -1;
        total++;
        if (cyc !== e) begin bad++; $display("FAIL phase_ch2_time: got %0d expected %0d", cyc - s, e - s); end
      end
      if (strobe_out[3] === 1'b1) begin
        int e;
        e = (exp3_q.size() > 0) ? exp3_q.pop_front() : -1;
        total++;
        if (cyc !== e) begin bad++; $display("FAIL phase_ch3_time: got %0d expected %0d", cyc - s, e - s); end
      end
    end
    total++;
    if (exp2_q.size() !== 0) begin bad++; $display("FAIL phase_ch2_missing: got %0d left expected 0", exp2_q.size()); end
    total++;
    if (exp3_q.size() !== 0) begin bad++; $display("FAIL phase_ch3_missing: got %0d left expected 0", exp3_q.size()); end
  endtask

  task automatic test_jitter();
    int t, prev;
    int rseq[$];
    cfg(1, 8, 0, 2);
    rnd = 5'd3;
    ch_en[1] = 1'b1;
    tick();
    prev = cyc;
    exp_q = '{9, 12, 10, 9, 9};
    rseq = '{1, 0, 8, 8, 0};
    while (exp_q.size() > 0) begin
      int ei;
      ei = exp_q.pop_front();
      wait_strobe(1, 30, t);
      rnd = 5'(rseq.pop_front());
      total++;
      if (t - prev !== ei) begin bad++; $display("FAIL jitter_period: got %0d expected %0d", t - prev, ei); end
      prev = t;
    end
  endtask

  task automatic test_reset_mid();
    int s, t;
    cfg(0, 3, 0, 0);
    total++;
    if (cfg_pend[0] !== 1'b1) begin bad++; $display("FAIL rstmid_pend_set: got %b expected 1", cfg_pend[0]); end
    #3 reset = 1'b0;
    #1;
    total++;
    if (clk_out !== 4'b0) begin bad++; $display("FAIL rstmid_clk: got %b expected 0000", clk_out); end
    total++;
    if (strobe_out !== 4'b0) begin bad++; $display("FAIL rstmid_strobe: got %b expected 0000", strobe_out); end
    total++;
    if (cfg_pend !== 4'b0) begin bad++; $display("FAIL rstmid_pend: got %b expected 0000", cfg_pend); end
    ch_en = 4'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    ch_en = 4'b0001;
    tick();
    s = cyc;
    wait_strobe(0, 20, t);
    total++;
    if (t - s !== 5) begin bad++; $display("FAIL rstmid_default_div: got %0d expected 5", t - s); end
    total++;
    if (clk_out[0] !== 1'b1) begin bad++; $display("FAIL rstmid_clk_toggle: got %b expected 1", clk_out[0]); end
  endtask

  task automatic test_bad_ch();
    int s;
    ch_en2 = 3'b111;
    tick();
    s = cyc;
    cfg_we2   = 1'b1;
    cfg_ch2   = 2'd3;
    cfg_div2  = 8'd1;
    cfg_mode2 = 2'd1;
    tick();
    cfg_we2 = 1'b0;
    total++;
    if (cfg_pend2 !== 3'b000) begin bad++; $display("FAIL badch_pend: got %b expected 000", cfg_pend2); end
    for (int k = 0; k < 9; k++) begin
      logic [5:0] e;
      tick();
      e = {((cyc - s) % 5 == 0) ? 3'b111 : 3'b000, (cyc - s >= 5 && cyc - s < 10) ? 3'b111 : 3'b000};
      total++;
      if ({strobe_out2, clk_out2} !== e)
        begin bad++; $display("FAIL badch_outputs: got %b expected %b", {strobe_out2, clk_out2}, e); end
    end
  endtask

  initial begin
    rnd = '0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_mode = '0;
    rnd2 = '0; ch_en2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_div2 = '0; cfg_phase2 = '0;
    cfg_mode2 = '0;
    test_reset();
    test_toggle();
    test_pulse();
    test_reconfig();
    test_phase();
    test_jitter();
    test_reset_mid();
    test_bad_ch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
